hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It drives the write-enable and flush controls of the IF/ID register, the PC write enable and the ID/EX bubble insert. It resolves load-use hazards, taken branches/jumps, multi-cycle mult/div occupancy of HI/LO, and halt. It sits beside the ID stage and sees the IF/ID instruction fields and the ID/EX load information.

## Interface
- MULT_CYCLES, 4: cycles the mult unit occupies HI/LO; legal range 2..64.
- DIV_CYCLES, 32: cycles the div unit occupies HI/LO; legal range 2..64.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- IFID_Rs  in  5  rs field of the instruction in ID.
- IFID_Rt  in  5  rt field of the instruction in ID.
- IFID_UsesRt  in  1  ID instruction reads rt as a source.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rt  in  5  destination of the load in EX.
- BranchTaken  in  1  ID resolved a taken branch or jump.
- MulDivStart  in  1  ID instruction is mult/multu/div/divu.
- MulDivIsDiv  in  1  qualifies MulDivStart: 1 = div, 0 = mult.
- IFID_IsHiLo  in  1  ID instruction reads HI/LO (mfhi/mflo) or is a mult/div.
- Halt  in  1  ID instruction is syscall/halt.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID instruction load enable (0 = hold).
- IFIDFlush  out  1  zero the next IF/ID instruction. Connects to the IF/ID Stall input.
- IDEXBubble  out  1  load zeros into the ID/EX control fields.
- MulDivBusy  out  1  HI/LO result pending.
- State  out  2  00 RUN, 01 MD_BUSY, 10 HALTED.

## Operation
- Registered state: 2-bit FSM and a 6-bit down-counter `cnt`. All outputs are combinational from state and the current inputs.
- Defaults: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- LU (load-use) = IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || (IFID_UsesRt && IDEX_Rt==IFID_Rt)).
- Stall action: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0.
- Priority per cycle, highest first:
  1. HALTED.
  2. LU.
  3. Halt.
  4. HI/LO stall (MD_BUSY && IFID_IsHiLo).
  5. BranchTaken / MulDivStart.
  - A lower-priority event is ignored in a cycle where a higher one applies. It is re-evaluated next cycle because ID is held.
- RUN:
  - LU: stall action; stay RUN.
  - Halt (no LU): stall action; next state HALTED.
  - BranchTaken: IFIDFlush=1, PCWrite=1.
  - MulDivStart: the instruction proceeds to EX. `cnt` loads MULT_CYCLES-1 or DIV_CYCLES-1 per MulDivIsDiv. Next state MD_BUSY.
- MD_BUSY:
  - MulDivBusy=1.
  - `cnt` decrements each cycle. When `cnt`==0 at an edge, next state is RUN.
  - IFID_IsHiLo (no LU, no Halt): stall action. This also blocks a second MulDivStart.
  - BranchTaken: flush as in RUN.
  - Halt (no LU): stall action; next state HALTED. The pending result is abandoned.
- HALTED: stall action every cycle. Leaves only on reset.
- MulDivStart together with BranchTaken cannot occur; behaviour is unspecified.

## Timing
- Reset:
  - At the edge where reset=1, next state is RUN and `cnt`=0.
  - While reset=1, outputs are forced: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0, MulDivBusy=0, State=00.
  - Reset during MD_BUSY or HALTED returns to RUN at that edge.
- Load-use: exactly one stall cycle. The bubble clears LU at the next edge.
- Branch: flush is asserted in the resolve cycle; a single wrong-path slot is zeroed.
- Mult/div: MulDivStart is sampled at edge k. MulDivBusy is high for exactly N cycles after edge k (N = MULT_CYCLES or DIV_CYCLES). A waiting mfhi is released in the first RUN cycle.
- Halt: stall action in the accepting cycle and every cycle after it.

## Test plan
- Load-use: lw writing $8 in EX; ID add uses rs=$8 -> one cycle of PCWrite=0/IFIDWrite=0/IDEXBubble=1, then defaults. Same with IDEX_Rt=0 -> no stall.
- Branch: BranchTaken=1 one cycle -> IFIDFlush=1, PCWrite=1 that cycle only. Branch with simultaneous LU -> stall only, no flush; flush on the following cycle.
- Mult: MULT_CYCLES=4, MulDivStart at edge k, mfhi in ID from k+1 -> State=01 and stall for cycles k+1..k+4; State=00 and release at k+5.
- Div back-to-back: DIV_CYCLES=32, div then mult in ID -> mult stalled 32 cycles, then accepted; MulDivBusy high for a further 4 cycles.
- Halt: Halt=1 in RUN -> State=10, permanent stall. Reset mid-HALTED and reset mid-MD_BUSY (cnt=17) -> State=00 and defaults at the next edge.
- Priority: Halt with LU -> stall stays in RUN until LU clears, then HALTED.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: load-use stalls,
// branch flushes, HI/LO occupancy of the mult/div unit, and halt.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic       IFID_UsesRt,
  input  logic       IDEX_MemRead,
  input  logic [4:0] IDEX_Rt,
  input  logic       BranchTaken,
  input  logic       MulDivStart,
  input  logic       MulDivIsDiv,
  input  logic       IFID_IsHiLo,
  input  logic       Halt,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXBubble,
  output logic       MulDivBusy,
  output logic [1:0] State
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MD_BUSY = 2'b01,
    HALTED  = 2'b10
  } state_e;

  localparam logic [5:0] MULT_LOAD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_CYCLES - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       lu;
  logic       stall;
  logic       flush;
  logic       busy;

  assign lu = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
              ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    flush   = 1'b0;
    busy    = 1'b0;
    case (state_q)
      RUN: begin
        if (lu) begin
          stall = 1'b1;
        end else if (Halt) begin
          stall   = 1'b1;
          state_d = HALTED;
        end else if (BranchTaken) begin
          flush = 1'b1;
        end else if (MulDivStart) begin
          cnt_d   = MulDivIsDiv ? DIV_LOAD : MULT_LOAD;
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        busy  = 1'b1;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd0) begin
          state_d = RUN;
          cnt_d   = 6'd0;
        end
        // A second mult/div also reads HI/LO, so it waits here like mfhi.
        if (lu) begin
          stall = 1'b1;
        end else if (Halt) begin
          stall   = 1'b1;
          state_d = HALTED;
          cnt_d   = 6'd0;
        end else if (IFID_IsHiLo) begin
          stall = 1'b1;
        end else if (BranchTaken) begin
          flush = 1'b1;
        end
      end
      HALTED: begin
        stall = 1'b1;
      end
      default: begin
        state_d = RUN;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    MulDivBusy = 1'b0;
    State      = 2'b00;
    if (!reset) begin
      PCWrite    = !stall;
      IFIDWrite  = !stall;
      IDEXBubble = stall;
      IFIDFlush  = flush;
      MulDivBusy = busy;
      State      = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected output vectors are queued with each
// stimulus step and checked against the DUT at the following falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IFID_Rs, IFID_Rt, IDEX_Rt;
  logic       IFID_UsesRt, IDEX_MemRead, BranchTaken, MulDivStart;
  logic       MulDivIsDiv, IFID_IsHiLo, Halt;
  logic       PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivBusy;
  logic [1:0] State;

  int tests = 0;
  int fails = 0;

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivBusy, State}
  localparam logic [6:0] DEF_RUN    = 7'b1100000;
  localparam logic [6:0] STALL_RUN  = 7'b0001000;
  localparam logic [6:0] FLUSH_RUN  = 7'b1110000;
  localparam logic [6:0] BUSY       = 7'b1100101;
  localparam logic [6:0] STALL_BUSY = 7'b0001101;
  localparam logic [6:0] FLUSH_BUSY = 7'b1110101;
  localparam logic [6:0] HALTV      = 7'b0001010;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_Rt(IDEX_Rt),
    .BranchTaken(BranchTaken), .MulDivStart(MulDivStart),
    .MulDivIsDiv(MulDivIsDiv), .IFID_IsHiLo(IFID_IsHiLo), .Halt(Halt),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
    .IDEXBubble(IDEXBubble), .MulDivBusy(MulDivBusy), .State(State)
  );

  task automatic clr();
    IFID_Rs = 5'd0; IFID_Rt = 5'd0; IDEX_Rt = 5'd0;
    IFID_UsesRt = 1'b0; IDEX_MemRead = 1'b0; BranchTaken = 1'b0;
    MulDivStart = 1'b0; MulDivIsDiv = 1'b0; IFID_IsHiLo = 1'b0; Halt = 1'b0;
  endtask

  // Inputs already driven; queue the expectation, check mid-cycle, advance.
  task automatic cyc(input logic [6:0] exp, input string tag);
    logic [6:0] got, want;
    string      t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    got  = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MulDivBusy, State};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%b exp=%b", t, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    reset = 1'b1;
    #1;
    cyc(DEF_RUN, "rst_force");
    Halt = 1'b1;
    cyc(DEF_RUN, "rst_halt_ignored");
    reset = 1'b0; Halt = 1'b0;
    cyc(DEF_RUN, "run_idle");

    // load-use on rs, one stall then bubble clears it
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd8; IFID_Rs = 5'd8;
    cyc(STALL_RUN, "lu_rs");
    IDEX_MemRead = 1'b0;
    cyc(DEF_RUN, "lu_after");
    IDEX_MemRead = 1'b1; IDEX_Rt = 5'd0; IFID_Rs = 5'd0;
    cyc(DEF_RUN, "lu_r0");
    IDEX_Rt = 5'd9; IFID_Rt = 5'd9; IFID_Rs = 5'd3; IFID_UsesRt = 1'b0;
    cyc(DEF_RUN, "lu_rt_unused");
    IFID_UsesRt = 1'b1;
    cyc(STALL_RUN, "lu_rt");
    clr();

    // branch, alone and with load-use
    BranchTaken = 1'b1;
    cyc(FLUSH_RUN, "br");
    BranchTaken = 1'b0;
    cyc(DEF_RUN, "br_after");
    BranchTaken = 1'b1; IDEX_MemRead = 1'b1; IDEX_Rt = 5'd4; IFID_Rs = 5'd4;
    cyc(STALL_RUN, "br_lu");
    IDEX_MemRead = 1'b0;
    cyc(FLUSH_RUN, "br_lu_next");
    clr();

    // mult then waiting mfhi
    MulDivStart = 1'b1; IFID_IsHiLo = 1'b1;
    cyc(DEF_RUN, "mult_start");
    MulDivStart = 1'b0;
    for (int i = 0; i < 4; i++) cyc(STALL_BUSY, "mfhi_wait");
    cyc(DEF_RUN, "mfhi_release");
    clr();

    // div then mult back-to-back
    MulDivStart = 1'b1; MulDivIsDiv = 1'b1; IFID_IsHiLo = 1'b1;
    cyc(DEF_RUN, "div_start");
    MulDivIsDiv = 1'b0;
    for (int i = 0; i < 32; i++) cyc(STALL_BUSY, "mult_held");
    cyc(DEF_RUN, "mult_accept");
    clr();
    for (int i = 0; i < 3; i++) cyc(BUSY, "mult_busy");
    BranchTaken = 1'b1;
    cyc(FLUSH_BUSY, "br_in_busy");
    BranchTaken = 1'b0;
    cyc(DEF_RUN, "mult_done");

    // reset with cnt=17 during div
    MulDivStart = 1'b1; MulDivIsDiv = 1'b1; IFID_IsHiLo = 1'b1;
    cyc(DEF_RUN, "div2_start");
    clr();
    for (int i = 0; i < 14; i++) cyc(BUSY, "div2_busy");
    reset = 1'b1;
    cyc(DEF_RUN, "rst_md_busy");
    reset = 1'b0;
    cyc(DEF_RUN, "after_rst_md");

    // halt abandons a pending mult
    MulDivStart = 1'b1; IFID_IsHiLo = 1'b1;
    cyc(DEF_RUN, "mult3_start");
    clr();
    cyc(BUSY, "mult3_busy");
    Halt = 1'b1;
    cyc(STALL_BUSY, "md_halt");
    Halt = 1'b0;
    cyc(HALTV, "md_halted");
    reset = 1'b1;
    cyc(DEF_RUN, "rst_halted1");
    reset = 1'b0;
    cyc(DEF_RUN, "after_rst_h1");

    // halt deferred behind load-use, then permanent stall
    Halt = 1'b1; IDEX_MemRead = 1'b1; IDEX_Rt = 5'd5; IFID_Rs = 5'd5;
    cyc(STALL_RUN, "halt_lu");
    IDEX_MemRead = 1'b0;
    cyc(STALL_RUN, "halt_accept");
    clr();
    cyc(HALTV, "halted_idle");
    BranchTaken = 1'b1;
    cyc(HALTV, "halted_br");
    BranchTaken = 1'b0; MulDivStart = 1'b1;
    cyc(HALTV, "halted_md");
    clr();
    reset = 1'b1;
    cyc(DEF_RUN, "rst_halted2");
    reset = 1'b0;
    cyc(DEF_RUN, "after_rst_h2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
